// File: rtl/demux4_rr_dispatcher.sv
// demux4_rr_dispatcher: one-entry buffer that offers each word to one of four channels, round-robin or fixed, skipping stalled channels after a timeout
module demux4_rr_dispatcher #(
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic [3:0]        out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic [3:0]        out_ready,
    input  logic              cfg_fixed_en,
    input  logic [1:0]        cfg_fixed_sel,
    output logic [1:0]        cur_sel,
    output logic              timeout_pulse,
    output logic              busy
);
    typedef enum logic {IDLE, OFFER} state_t;

    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam logic             SKIP_EN   = (TIMEOUT != 0);

    state_t            state_q, state_d;
    logic [1:0]        rr_ptr_q, rr_ptr_d;
    logic [1:0]        sel_q, sel_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              fixed_q, fixed_d;
    logic              timeout_pulse_q, timeout_pulse_d;
    logic              out_xfer, in_xfer, skip;
    logic [1:0]        rr_next;

    // Handshakes; a word leaving on a channel and a new word arriving can share a cycle, and the new word then targets the advanced pointer
    always_comb begin
        busy     = (state_q == OFFER);
        out_xfer = busy & out_ready[sel_q];
        in_ready = rst_n & (~busy | out_xfer);
        in_xfer  = in_valid & in_ready;
        rr_next  = (out_xfer & ~fixed_q) ? sel_q + 2'd1 : rr_ptr_q;
        skip     = busy & ~out_xfer & ~fixed_q & SKIP_EN & (wait_cnt_q == WAIT_LAST);
    end

    // Next-state: load on in_xfer, release on out_xfer, otherwise count the stall and skip when it expires
    always_comb begin
        state_d         = in_xfer ? OFFER : (out_xfer ? IDLE : state_q);
        data_d          = in_xfer ? in_data : data_q;
        fixed_d         = in_xfer ? cfg_fixed_en : fixed_q;
        rr_ptr_d        = rr_next;
        sel_d           = in_xfer ? (cfg_fixed_en ? cfg_fixed_sel : rr_next) : (skip ? sel_q + 2'd1 : sel_q);
        wait_cnt_d      = (in_xfer | skip | ~busy | fixed_q | ~SKIP_EN) ? '0 : wait_cnt_q + CNT_W'(1);
        timeout_pulse_d = skip;
    end

    // State registers; reset drops any buffered word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            rr_ptr_q        <= 2'd0;
            sel_q           <= 2'd0;
            wait_cnt_q      <= '0;
            data_q          <= '0;
            fixed_q         <= 1'b0;
            timeout_pulse_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            rr_ptr_q        <= rr_ptr_d;
            sel_q           <= sel_d;
            wait_cnt_q      <= wait_cnt_d;
            data_q          <= data_d;
            fixed_q         <= fixed_d;
            timeout_pulse_q <= timeout_pulse_d;
        end
    end

    // One-hot offer on the selected channel while the buffer is full
    always_comb begin
        out_valid     = busy ? (4'b0001 << sel_q) : 4'b0000;
        out_data      = data_q;
        cur_sel       = sel_q;
        timeout_pulse = timeout_pulse_q;
    end
endmodule

// File: tb/tb_demux4_rr_dispatcher.sv
// tb_demux4_rr_dispatcher: randomized and directed checks against a transaction-level model
module tb_demux4_rr_dispatcher;
    localparam int TO = 3;

    logic       clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, cfg_fixed_en = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic [3:0] out_ready = 4'h0;
    logic [1:0] cfg_fixed_sel = 2'd0;
    logic       in_ready, timeout_pulse, busy;
    logic [3:0] out_valid;
    logic [7:0] out_data;
    logic [1:0] cur_sel;

    int errors = 0, checks = 0;

    demux4_rr_dispatcher #(.DATA_W(8), .TIMEOUT(TO), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .cfg_fixed_en(cfg_fixed_en), .cfg_fixed_sel(cfg_fixed_sel),
        .cur_sel(cur_sel), .timeout_pulse(timeout_pulse), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference model: a buffer slot holding a word, its target channel, how long it has waited, and the round-robin pointer
    typedef struct { int ch; logic [7:0] w; } xfer_t;
    xfer_t      xq[$];
    logic [7:0] sent[$];
    logic       m_full, m_fixed, m_pulse, m_ox, m_ix, e_ready;
    logic [7:0] m_word;
    int         m_ch, m_rr, m_wait, m_rrn;
    logic [3:0] e_valid;
    logic [17:0] exp_v, obs_v;

    always_comb begin
        m_ox    = m_full && out_ready[m_ch];
        m_ix    = rst_n && in_valid && (!m_full || m_ox);
        m_rrn   = (m_ox && !m_fixed) ? (m_ch + 1) % 4 : m_rr;
        e_ready = rst_n && (!m_full || out_ready[m_ch]);
        e_valid = m_full ? 4'(1 << m_ch) : 4'b0000;
        exp_v   = {e_valid, m_word, e_ready, 2'(m_ch), m_pulse, m_full};
        obs_v   = {out_valid, out_data, in_ready, cur_sel, timeout_pulse, busy};
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_full <= 1'b0; m_fixed <= 1'b0; m_pulse <= 1'b0; m_word <= 8'h00;
            m_ch <= 0; m_rr <= 0; m_wait <= 0;
        end else begin
            m_pulse <= 1'b0;
            m_rr    <= m_rrn;
            if (m_ox) xq.push_back(xfer_t'{m_ch, m_word});
            if (m_ix) begin
                sent.push_back(in_data);
                m_full  <= 1'b1;
                m_word  <= in_data;
                m_fixed <= cfg_fixed_en;
                m_ch    <= cfg_fixed_en ? int'(cfg_fixed_sel) : m_rrn;
                m_wait  <= 0;
            end else if (m_ox) begin
                m_full <= 1'b0;
            end else if (m_full && !m_fixed && TO != 0) begin
                if (m_wait == TO - 1) begin
                    m_ch    <= (m_ch + 1) % 4;
                    m_wait  <= 0;
                    m_pulse <= 1'b1;
                end else begin
                    m_wait <= m_wait + 1;
                end
            end
        end
    end

    task automatic test_reset;
        #1;
        if ({out_valid, busy, in_ready, out_data, timeout_pulse} !== 15'd0) begin
            errors++; $display("FAIL reset_hold: got %h want 0", {out_valid, busy, in_ready, out_data, timeout_pulse});
        end
        checks++;
        @(negedge clk); rst_n = 1'b1; #1;
        if (in_ready !== 1'b1 || obs_v !== exp_v) begin
            errors++; $display("FAIL reset_release: got in_ready=%b obs=%h want 1 %h", in_ready, obs_v, exp_v);
        end
        checks++;
    endtask

    task automatic test_rr_stream;
        xq.delete(); sent.delete();
        out_ready = 4'hF; cfg_fixed_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); in_valid = (i < 6); in_data = 8'hA0 + 8'(i); #1;
            if (obs_v !== exp_v || (i < 6 && in_ready !== 1'b1)) begin
                errors++; $display("FAIL rr_stream cyc %0d: got %h want %h", i, obs_v, exp_v);
            end
            checks++;
        end
        in_valid = 1'b0;
        if (xq.size() != 6) begin
            errors++; $display("FAIL rr_stream_count: got %0d want 6", xq.size());
        end
        checks++;
        for (int k = 0; k < xq.size() && k < 6; k++) begin
            if (xq[k].ch != k % 4 || xq[k].w !== 8'hA0 + 8'(k)) begin
                errors++; $display("FAIL rr_stream_order %0d: got ch%0d %h want ch%0d %h", k, xq[k].ch, xq[k].w, k % 4, 8'hA0 + 8'(k));
            end
            checks++;
        end
    endtask

    task automatic test_reset_mid;
        out_ready = 4'h0;
        @(negedge clk); in_valid = 1'b1; in_data = 8'h3C;
        @(negedge clk); in_valid = 1'b0; #1;
        if (busy !== 1'b1 || out_valid !== 4'b0100) begin
            errors++; $display("FAIL reset_mid_pre: got busy=%b valid=%b want 1 0100", busy, out_valid);
        end
        checks++;
        #1 rst_n = 1'b0; #1;
        if ({out_valid, busy, in_ready, out_data} !== 14'd0) begin
            errors++; $display("FAIL reset_mid_async: got %h want 0", {out_valid, busy, in_ready, out_data});
        end
        checks++;
        @(negedge clk); rst_n = 1'b1; out_ready = 4'hF;
        @(negedge clk); in_valid = 1'b1; in_data = 8'h4D;
        @(negedge clk); in_valid = 1'b0; #1;
        if (cur_sel !== 2'd0 || out_valid !== 4'b0001 || obs_v !== exp_v) begin
            errors++; $display("FAIL reset_mid_rr0: got sel=%0d valid=%b want 0 0001", cur_sel, out_valid);
        end
        checks++;
    endtask

    task automatic test_timeout;
        int pulses = 0, on0 = 0;
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        xq.delete(); out_ready = 4'b1110; cfg_fixed_en = 1'b0;
        @(negedge clk); in_valid = 1'b1; in_data = 8'h55;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); in_valid = 1'b0; #1;
            if (obs_v !== exp_v) begin
                errors++; $display("FAIL timeout cyc %0d: got %h want %h", i, obs_v, exp_v);
            end
            checks++;
            pulses += int'(timeout_pulse);
            on0    += int'(out_valid == 4'b0001);
        end
        if (pulses != 1 || on0 != 3) begin
            errors++; $display("FAIL timeout_counts: got pulses=%0d ch0=%0d want 1 3", pulses, on0);
        end
        checks++;
        out_ready = 4'hF;
        @(negedge clk); in_valid = 1'b1; in_data = 8'h66;
        @(negedge clk); in_valid = 1'b0;
        @(negedge clk);
        if (xq.size() != 2 || xq[0].ch != 1 || xq[0].w !== 8'h55 || xq[1].ch != 2) begin
            errors++; $display("FAIL timeout_route: got n=%0d want 55@ch1 then ch2", xq.size());
        end
        checks++;
    endtask

    task automatic test_fixed;
        int rr0 = m_rr;
        xq.delete(); cfg_fixed_en = 1'b1; cfg_fixed_sel = 2'd2; out_ready = 4'b1011;
        @(negedge clk); in_valid = 1'b1; in_data = 8'h77;
        @(negedge clk); in_data = 8'h88;
        for (int i = 0; i < 40; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            if (obs_v !== exp_v || out_valid !== 4'b0100 || timeout_pulse !== 1'b0 || in_ready !== 1'b0 || out_data !== 8'h77) begin
                errors++; $display("FAIL fixed_hold cyc %0d: got %h want %h", i, obs_v, exp_v);
            end
            checks++;
        end
        @(negedge clk); out_ready = 4'hF; #1;
        if (in_ready !== 1'b1 || obs_v !== exp_v) begin
            errors++; $display("FAIL fixed_release: got %h want %h", obs_v, exp_v);
        end
        checks++;
        @(negedge clk); in_valid = 1'b0; cfg_fixed_en = 1'b0;
        @(negedge clk); in_valid = 1'b1; in_data = 8'h99;
        @(negedge clk); in_valid = 1'b0;
        @(negedge clk);
        if (xq.size() != 3 || xq[0].ch != 2 || xq[1].ch != 2 || xq[1].w !== 8'h88 || xq[2].ch != rr0) begin
            errors++; $display("FAIL fixed_rr_unchanged: got n=%0d want 3 ending ch%0d", xq.size(), rr0);
        end
        checks++;
    endtask

    task automatic test_back_to_back;
        int first;
        xq.delete(); sent.delete(); out_ready = 4'hF; cfg_fixed_en = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk); in_valid = (i < 10); in_data = 8'($urandom); #1;
            if (obs_v !== exp_v || (i > 0 && i < 11 && busy !== 1'b1)) begin
                errors++; $display("FAIL b2b cyc %0d: got %h want %h", i, obs_v, exp_v);
            end
            checks++;
        end
        in_valid = 1'b0;
        if (xq.size() != 10 || sent.size() != 10) begin
            errors++; $display("FAIL b2b_count: got %0d/%0d want 10", xq.size(), sent.size());
        end else begin
            first = xq[0].ch;
            for (int k = 0; k < 10; k++) begin
                if (xq[k].w !== sent[k] || xq[k].ch != (first + k) % 4) begin
                    errors++; $display("FAIL b2b_word %0d: got %h ch%0d want %h ch%0d", k, xq[k].w, xq[k].ch, sent[k], (first + k) % 4);
                end
            end
        end
        checks++;
    endtask

    task automatic test_all_stall;
        int pulses = 0, start;
        logic [7:0] w;
        xq.delete(); out_ready = 4'h0; w = 8'($urandom);
        @(negedge clk); in_valid = 1'b1; in_data = w;
        @(negedge clk); in_valid = 1'b0; #1; start = int'(cur_sel);
        for (int i = 0; i < 20; i++) begin
            if (i > 0) begin @(negedge clk); #1; end
            if (obs_v !== exp_v || out_data !== w || int'(cur_sel) != (start + i / TO) % 4) begin
                errors++; $display("FAIL stall cyc %0d: got %h sel=%0d want %h sel=%0d", i, obs_v, cur_sel, exp_v, (start + i / TO) % 4);
            end
            checks++;
            pulses += int'(timeout_pulse);
        end
        if (pulses != 6) begin
            errors++; $display("FAIL stall_pulses: got %0d want 6", pulses);
        end
        checks++;
        out_ready = 4'b1000;
        for (int i = 0; i < 16 && busy; i++) @(negedge clk);
        if (busy !== 1'b0 || xq.size() != 1 || xq[0].ch != 3 || xq[0].w !== w) begin
            errors++; $display("FAIL stall_take: got busy=%b n=%0d want 0 1 word %h on ch3", busy, xq.size(), w);
        end
        checks++;
    endtask

    task automatic test_random;
        xq.delete(); sent.delete();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            in_valid = ($urandom_range(0, 2) != 0);
            in_data = 8'($urandom);
            out_ready = 4'($urandom);
            cfg_fixed_en = ($urandom_range(0, 3) == 0);
            cfg_fixed_sel = 2'($urandom);
            #1;
            if (obs_v !== exp_v) begin
                errors++; $display("FAIL random cyc %0d: got %h want %h", i, obs_v, exp_v);
            end
            checks++;
        end
        @(negedge clk); in_valid = 1'b0; out_ready = 4'hF;
        for (int i = 0; i < 8 && busy; i++) @(negedge clk);
        if (busy !== 1'b0 || xq.size() != sent.size()) begin
            errors++; $display("FAIL random_drain: got busy=%b out=%0d want 0 %0d", busy, xq.size(), sent.size());
        end else begin
            for (int k = 0; k < xq.size(); k++) begin
                if (xq[k].w !== sent[k]) begin
                    errors++; $display("FAIL random_order %0d: got %h want %h", k, xq[k].w, sent[k]);
                end
            end
        end
        checks++;
    endtask

    initial begin
        test_reset();
        test_rr_stream();
        test_reset_mid();
        test_timeout();
        test_fixed();
        test_back_to_back();
        test_all_stall();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
